am_mod_dds: RTL and testbench

- Digital direct-digital-synthesis source for the modulating term of the AM modulator macro: m·sin(2π·f·t + Phase).
- Output samples are consumed by a DAC/behavioural converter that drives the modulator's third (modulation) port.
- Provides a glitch-free frequency, phase and depth update handshake, so modulation parameters change only at a waveform period boundary.

---
 rtl/am_mod_dds.sv | 241 ++++++++++++++++++++++++
 tb/tb_am_mod_dds.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/am_mod_dds.sv
// am_mod_dds: DDS source for the AM modulating term m*sin(2*pi*f*t + phase).
// Frequency, phase and depth updates take effect only at a waveform period
// boundary (accumulator carry-out) or when the generator drops to idle.
// Optional feature macro: AM_MOD_DDS_DITHER_EN adds LFSR phase dithering
// ahead of the phase truncation.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accumulator held at 0, output flushed, config written directly
// RUN   | accumulator advances by ftw, config staged until carry-out
module am_mod_dds #(
    parameter int PHASE_W = 24,
    parameter int LUT_AW  = 8,
    parameter int OUT_W   = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [PHASE_W-1:0]      cfg_ftw,
    input  logic [PHASE_W-1:0]      cfg_phase,
    input  logic [7:0]              cfg_depth,
    output logic                    mod_valid,
    output logic signed [OUT_W-1:0] mod_data,
    output logic                    wrap
);

    localparam int  PW    = LUT_AW + 2;
    localparam int  TRUNC = PHASE_W - PW;
    localparam int  QN    = 1 << LUT_AW;
    localparam int  AMP   = (1 << (OUT_W - 1)) - 1;
    localparam real PI    = 3.14159265358979323846;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0] ftw_q, ftw_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [7:0]         depth_q, depth_d;

    logic               pend_vld_q, pend_vld_d;
    logic [PHASE_W-1:0] pend_ftw_q, pend_ftw_d;
    logic [PHASE_W-1:0] pend_phase_q, pend_phase_d;
    logic [7:0]         pend_depth_q, pend_depth_d;

    logic               wrap_q, wrap_d;

    logic               v1_q, v1_d;
    logic               v2_q, v2_d;
    logic               mod_valid_q, mod_valid_d;
    logic [PW-1:0]      p_q, p_d;
    logic [7:0]         d1_q, d1_d;
    logic signed [OUT_W-1:0] s_q, s_d;
    logic [7:0]         d2_q, d2_d;
    logic signed [OUT_W-1:0] mod_data_q, mod_data_d;

    logic               hs;
    logic               run_stay;
    logic               carry;
    logic [PHASE_W-1:0] acc_sum;
    logic [PHASE_W-1:0] phase_sum;
    logic [1:0]         quad;
    logic [LUT_AW:0]    lut_addr;
    logic [OUT_W-2:0]   lut_mag;
    logic signed [OUT_W-1:0] mag_s;
    logic signed [OUT_W+8:0] prod;

`ifdef AM_MOD_DDS_DITHER_EN
    logic [15:0]        lfsr_q, lfsr_d;
    logic [PHASE_W-1:0] dith;
`endif

    // Quarter-wave sine table, entries 0..QN inclusive so the peak is exact.
    logic [OUT_W-2:0] lut [0:QN];
    for (genvar gi = 0; gi <= QN; gi++) begin : g_lut
        localparam real ANG = 2.0 * PI * real'(gi) / real'(4 * QN);
        localparam int  VAL = $rtoi(real'(AMP) * $sin(ANG) + 0.5);
        assign lut[gi] = (OUT_W-1)'(VAL);
    end

    assign cfg_ready = ~pend_vld_q;
    assign hs        = cfg_valid & cfg_ready;
    assign run_stay  = (state_q == S_RUN) && en;
    assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, ftw_q};

    // State machine, accumulator and active/pending configuration.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        ftw_d        = ftw_q;
        phase_d      = phase_q;
        depth_d      = depth_q;
        pend_vld_d   = pend_vld_q;
        pend_ftw_d   = pend_ftw_q;
        pend_phase_d = pend_phase_q;
        pend_depth_d = pend_depth_q;
        wrap_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                acc_d = '0;
                if (hs) begin
                    ftw_d   = cfg_ftw;
                    phase_d = cfg_phase;
                    depth_d = cfg_depth;
                end
                if (en) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!en) begin
                    // Leaving: staged or offered config lands now, accumulator restarts.
                    state_d    = S_IDLE;
                    acc_d      = '0;
                    pend_vld_d = 1'b0;
                    if (pend_vld_q) begin
                        ftw_d   = pend_ftw_q;
                        phase_d = pend_phase_q;
                        depth_d = pend_depth_q;
                    end else if (hs) begin
                        ftw_d   = cfg_ftw;
                        phase_d = cfg_phase;
                        depth_d = cfg_depth;
                    end
                end else begin
                    acc_d  = acc_sum;
                    wrap_d = carry;
                    if (carry && pend_vld_q) begin
                        ftw_d      = pend_ftw_q;
                        phase_d    = pend_phase_q;
                        depth_d    = pend_depth_q;
                        pend_vld_d = 1'b0;
                    end
                    // hs implies nothing pending, so this never collides with the copy above.
                    if (hs) begin
                        pend_ftw_d   = cfg_ftw;
                        pend_phase_d = cfg_phase;
                        pend_depth_d = cfg_depth;
                        pend_vld_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                acc_d   = '0;
            end
        endcase
    end

    // Three-stage sample pipeline: phase truncate, sine lookup, depth scaling.
    always_comb begin
`ifdef AM_MOD_DDS_DITHER_EN
        dith      = PHASE_W'(lfsr_q) & ((PHASE_W'(1) << TRUNC) - PHASE_W'(1));
        phase_sum = acc_q + phase_q + dith;
        lfsr_d    = lfsr_q;
        if (state_q == S_RUN) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
`else
        phase_sum = acc_q + phase_q;
`endif
        p_d  = PW'(phase_sum >> TRUNC);
        d1_d = depth_q;

        quad     = p_q[PW-1:PW-2];
        lut_addr = quad[0] ? ((LUT_AW+1)'(QN) - {1'b0, p_q[LUT_AW-1:0]})
                           : {1'b0, p_q[LUT_AW-1:0]};
        lut_mag  = lut[lut_addr];
        mag_s    = $signed({1'b0, lut_mag});
        s_d      = quad[1] ? -mag_s : mag_s;
        d2_d     = d1_q;

        // Depth kept aligned with its sample so a depth change never splits a period.
        prod = $signed({{9{s_q[OUT_W-1]}}, s_q}) * $signed({{(OUT_W+1){1'b0}}, d2_q});

        v1_d        = run_stay;
        v2_d        = run_stay & v1_q;
        mod_valid_d = run_stay & v2_q;
        mod_data_d  = (run_stay && v2_q) ? OUT_W'(prod >>> 8) : '0;
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            ftw_q        <= '0;
            phase_q      <= '0;
            depth_q      <= '0;
            pend_vld_q   <= 1'b0;
            pend_ftw_q   <= '0;
            pend_phase_q <= '0;
            pend_depth_q <= '0;
            wrap_q       <= 1'b0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            mod_valid_q  <= 1'b0;
            p_q          <= '0;
            d1_q         <= '0;
            s_q          <= '0;
            d2_q         <= '0;
            mod_data_q   <= '0;
`ifdef AM_MOD_DDS_DITHER_EN
            lfsr_q       <= 16'hACE1;
`endif
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            ftw_q        <= ftw_d;
            phase_q      <= phase_d;
            depth_q      <= depth_d;
            pend_vld_q   <= pend_vld_d;
            pend_ftw_q   <= pend_ftw_d;
            pend_phase_q <= pend_phase_d;
            pend_depth_q <= pend_depth_d;
            wrap_q       <= wrap_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            mod_valid_q  <= mod_valid_d;
            p_q          <= p_d;
            d1_q         <= d1_d;
            s_q          <= s_d;
            d2_q         <= d2_d;
            mod_data_q   <= mod_data_d;
`ifdef AM_MOD_DDS_DITHER_EN
            lfsr_q       <= lfsr_d;
`endif
        end
    end

    assign mod_valid = mod_valid_q;
    assign mod_data  = mod_data_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_am_mod_dds.sv
// Directed bench for am_mod_dds: fixed config vectors, hand-computed samples.
module tb_am_mod_dds;

    logic                clk;
    logic                rst;
    logic                en;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [23:0]         cfg_ftw;
    logic [23:0]         cfg_phase;
    logic [7:0]          cfg_depth;
    logic                mod_valid;
    logic signed [11:0]  mod_data;
    logic                wrap;

    int checks = 0;
    int errors = 0;

    int q4_full  [4] = '{0, 2039, 0, -2040};
    int q4_shift [4] = '{2039, 0, -2040, 0};
    int q4_half  [4] = '{0, 1023, 0, -1024};
    int q8_full  [8] = '{0, 1441, 2039, 1441, 0, -1442, -2040, -1442};

    am_mod_dds #(.PHASE_W(24), .LUT_AW(8), .OUT_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ftw   (cfg_ftw),
        .cfg_phase (cfg_phase),
        .cfg_depth (cfg_depth),
        .mod_valid (mod_valid),
        .mod_data  (mod_data),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [23:0] f, input logic [23:0] p, input logic [7:0] d);
        cfg_valid = 1'b1;
        cfg_ftw   = f;
        cfg_phase = p;
        cfg_depth = d;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        cfg_ftw = '0; cfg_phase = '0; cfg_depth = '0;
        tick();
        tick();
        chk("rst_valid", mod_valid, 0);
        chk("rst_data", mod_data, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_ready", cfg_ready, 1);
        rst = 1'b0;

        // IDLE config, 4-sample period, then a mid-period switch to 8 samples.
        offer(24'h400000, 24'h0, 8'd255);
        tick();
        cfg_valid = 1'b0;
        en = 1'b1;
        tick();
        for (int k = 0; k <= 27; k++) begin
            chk("f4f8_wrap", wrap, (k == 4 || k == 8 || k == 12 || k == 16 || k == 24) ? 1 : 0);
            chk("f4f8_valid", mod_valid, (k >= 3) ? 1 : 0);
            if (k < 3)       chk("f4f8_data", mod_data, 0);
            else if (k < 19) chk("f4f8_data", mod_data, q4_full[(k - 3) % 4]);
            else             chk("f4f8_data", mod_data, q8_full[(k - 19) % 8]);
            if (k == 14 || k == 15) chk("f4f8_ready_low", cfg_ready, 0);
            if (k == 16)            chk("f4f8_ready_back", cfg_ready, 1);
            if (k == 13) begin
                chk("f4f8_ready_offer", cfg_ready, 1);
                offer(24'h200000, 24'h0, 8'd255);
            end else begin
                cfg_valid = 1'b0;
            end
            tick();
        end

        // Handshake together with en=0: applied directly (depth 128).
        chk("dir_ready", cfg_ready, 1);
        offer(24'h400000, 24'h0, 8'd128);
        en = 1'b0;
        tick();
        cfg_valid = 1'b0;
        chk("stop_valid", mod_valid, 0);
        chk("stop_data", mod_data, 0);
        chk("stop_wrap", wrap, 0);
        chk("stop_ready", cfg_ready, 1);
        en = 1'b1;
        tick();
        for (int k = 0; k <= 6; k++) begin
            chk("half_valid", mod_valid, (k >= 3) ? 1 : 0);
            chk("half_data", mod_data, (k >= 3) ? q4_half[(k - 3) % 4] : 0);
            if (k == 5) begin
                chk("half_ready", cfg_ready, 1);
                offer(24'h400000, 24'h400000, 8'd255);
            end else begin
                cfg_valid = 1'b0;
            end
            if (k == 6) begin
                chk("half_pend", cfg_ready, 0);
                en = 1'b0;
            end
            tick();
        end

        // Pending config applied on leaving RUN: phase offset now 2^22.
        chk("leave_valid", mod_valid, 0);
        chk("leave_ready", cfg_ready, 1);
        en = 1'b1;
        tick();
        for (int k = 0; k <= 6; k++) begin
            chk("shift_valid", mod_valid, (k >= 3) ? 1 : 0);
            chk("shift_data", mod_data, (k >= 3) ? q4_shift[(k - 3) % 4] : 0);
            if (k == 6) offer(24'h400000, 24'h0, 8'd255);
            tick();
        end
        cfg_valid = 1'b0;
        chk("pre_rst_pend", cfg_ready, 0);

        // Reset mid-RUN with a pending config.
        rst = 1'b1;
        en  = 1'b0;
        tick();
        rst = 1'b0;
        chk("mrst_valid", mod_valid, 0);
        chk("mrst_data", mod_data, 0);
        chk("mrst_ready", cfg_ready, 1);
        en = 1'b1;
        tick();
        for (int k = 0; k <= 12; k++) begin
            chk("zero_valid", mod_valid, (k >= 3) ? 1 : 0);
            chk("zero_data", mod_data, 0);
            chk("zero_wrap", wrap, 0);
            if (k >= 5) chk("ftw0_pend_held", cfg_ready, 0);
            if (k == 4) begin
                chk("ftw0_ready", cfg_ready, 1);
                offer(24'h400000, 24'h400000, 8'd255);
            end else begin
                cfg_valid = 1'b0;
            end
            if (k == 12) en = 1'b0;
            tick();
        end

        // Pending from the ftw=0 run becomes active once en drops.
        chk("ftw0_leave_ready", cfg_ready, 1);
        en = 1'b1;
        tick();
        for (int k = 0; k <= 6; k++) begin
            chk("ftw0_after_data", mod_data, (k >= 3) ? q4_shift[(k - 3) % 4] : 0);
            if (k == 6) en = 1'b0;
            tick();
        end

        // Depth 0: valid samples, all zero.
        offer(24'h400000, 24'h400000, 8'd0);
        tick();
        cfg_valid = 1'b0;
        en = 1'b1;
        tick();
        for (int k = 0; k <= 6; k++) begin
            chk("d0_valid", mod_valid, (k >= 3) ? 1 : 0);
            chk("d0_data", mod_data, 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
